// File: rtl/psram_word_bridge.sv
// psram_word_bridge: splits 32-bit word reads/writes from the core into one
// or two 16-bit halfword transactions on the psram controller.
module psram_word_bridge #(
  parameter int ADDR_BANK_BIT = 23
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        psram_bank_sel,
  output logic [21:0] psram_addr,
  output logic        psram_write_en,
  output logic        psram_read_en,
  output logic [15:0] psram_data_in,
  output logic        psram_write_high_byte,
  output logic        psram_write_low_byte,
  input  logic        psram_busy,
  input  logic        psram_read_avail,
  input  logic [15:0] psram_data_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]  r_state;
  logic        r_half;
  logic        r_we;
  logic [20:0] r_word_addr;
  logic [15:0] r_wdata_hi;
  logic [1:0]  r_wstrb_hi;
  logic [15:0] r_lo_data;
  logic [15:0] r_hi_data;
  logic [31:0] r_rdata;
  logic        r_rd_en;
  logic        r_wr_en;
  logic [21:0] r_paddr;
  logic [15:0] r_pdata;
  logic        r_pbank;
  logic        r_hb;
  logic        r_lb;

  logic        w_accept;
  logic        w_lo_first;
  logic        w_need_hi;
  logic [15:0] w_hi_data;
  logic        w_unused;

  assign w_accept   = req_valid && req_ready;
  // A write whose low strobes are clear starts directly on the HI half.
  assign w_lo_first = !req_we || (req_wstrb[1:0] != 2'b00);
  // After the LO half: reads always continue, writes only if HI has strobes.
  assign w_need_hi  = !r_we || (r_wstrb_hi != 2'b00);
  // HI read data may arrive in the same cycle busy drops.
  assign w_hi_data  = psram_read_avail ? psram_data_out : r_hi_data;
  assign w_unused   = &{1'b0, req_addr[31:23], req_addr[1:0]};

  assign req_ready             = (r_state == S_IDLE) && !psram_busy;
  assign resp_valid            = (r_state == S_RESP);
  assign resp_rdata            = r_rdata;
  assign psram_bank_sel        = r_pbank;
  assign psram_addr            = r_paddr;
  assign psram_write_en        = r_wr_en;
  assign psram_read_en         = r_rd_en;
  assign psram_data_in         = r_pdata;
  assign psram_write_high_byte = r_hb;
  assign psram_write_low_byte  = r_lb;

  // Request FSM: accept, issue each needed half, wait out the controller, respond.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_half      <= 1'b0;
      r_we        <= 1'b0;
      r_word_addr <= '0;
      r_wdata_hi  <= '0;
      r_wstrb_hi  <= '0;
      r_lo_data   <= '0;
      r_hi_data   <= '0;
      r_rdata     <= '0;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_paddr     <= '0;
      r_pdata     <= '0;
      r_pbank     <= 1'b0;
      r_hb        <= 1'b0;
      r_lb        <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we        <= req_we;
            r_word_addr <= req_addr[22:2];
            r_wdata_hi  <= req_wdata[31:16];
            r_wstrb_hi  <= req_wstrb[3:2];
            if (req_we && (req_wstrb == 4'b0000)) begin
              r_state <= S_RESP;
            end else begin
              // Enables and halfword fields are registered here so they are
              // visible during the ISSUE cycle.
              r_state <= S_ISSUE;
              r_half  <= !w_lo_first;
              r_pbank <= req_addr[ADDR_BANK_BIT];
              r_paddr <= {req_addr[22:2], !w_lo_first};
              r_pdata <= w_lo_first ? req_wdata[15:0] : req_wdata[31:16];
              r_hb    <= !req_we || (w_lo_first ? req_wstrb[1] : req_wstrb[3]);
              r_lb    <= !req_we || (w_lo_first ? req_wstrb[0] : req_wstrb[2]);
              r_rd_en <= !req_we;
              r_wr_en <= req_we;
            end
          end
        end
        S_ISSUE: r_state <= S_GAP;
        S_GAP:   r_state <= S_WAIT;
        S_WAIT: begin
          if (psram_read_avail && !r_we) begin
            if (r_half) r_hi_data <= psram_data_out;
            else        r_lo_data <= psram_data_out;
          end
          if (!psram_busy) begin
            if (!r_half && w_need_hi) begin
              r_state <= S_ISSUE;
              r_half  <= 1'b1;
              r_paddr <= {r_word_addr, 1'b1};
              r_pdata <= r_wdata_hi;
              r_hb    <= !r_we || r_wstrb_hi[1];
              r_lb    <= !r_we || r_wstrb_hi[0];
              r_rd_en <= !r_we;
              r_wr_en <= r_we;
            end else begin
              r_state <= S_RESP;
              if (!r_we) r_rdata <= {w_hi_data, r_lo_data};
            end
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_word_bridge.sv
// Bench for psram_word_bridge: psram controller model, request-level
// scoreboard, and directed word read/write scenarios.
module tb_psram_word_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        psram_bank_sel;
  logic [21:0] psram_addr;
  logic        psram_write_en;
  logic        psram_read_en;
  logic [15:0] psram_data_in;
  logic        psram_write_high_byte;
  logic        psram_write_low_byte;
  logic        psram_busy;
  logic        psram_read_avail;
  logic [15:0] psram_data_out;

  always #5 clk = ~clk;

  psram_word_bridge #(.ADDR_BANK_BIT(23)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .psram_bank_sel(psram_bank_sel), .psram_addr(psram_addr),
    .psram_write_en(psram_write_en), .psram_read_en(psram_read_en),
    .psram_data_in(psram_data_in),
    .psram_write_high_byte(psram_write_high_byte),
    .psram_write_low_byte(psram_write_low_byte),
    .psram_busy(psram_busy), .psram_read_avail(psram_read_avail),
    .psram_data_out(psram_data_out)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- controller model ----------------
  logic [15:0] mem [0:1][0:255];
  bit          mem_init = 1'b0;
  int          b_cfg = 3;
  int          mb_cnt = 0;
  bit          mb_rd = 1'b0;
  logic [15:0] mb_rdata = '0;

  assign psram_busy       = (mb_cnt > 0);
  assign psram_read_avail = mb_rd && (mb_cnt == 1);
  assign psram_data_out   = mb_rdata;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < 256; a++) mem[b][a] <= 16'h0000;
      mem[0][8] <= 16'hBEEF;
      mem[0][9] <= 16'hDEAD;
      mem_init  <= 1'b1;
    end else if (psram_read_en || psram_write_en) begin
      mb_cnt <= b_cfg;
      mb_rd  <= psram_read_en;
      if (psram_read_en) mb_rdata <= mem[psram_bank_sel][psram_addr[7:0]];
      if (psram_write_en) begin
        if (psram_write_high_byte)
          mem[psram_bank_sel][psram_addr[7:0]][15:8] <= psram_data_in[15:8];
        if (psram_write_low_byte)
          mem[psram_bank_sel][psram_addr[7:0]][7:0] <= psram_data_in[7:0];
      end
    end else if (mb_cnt > 0) begin
      mb_cnt <= mb_cnt - 1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        we;
    logic        bank;
    logic [21:0] addr;
    logic [15:0] data;
    logic        hb;
    logic        lb;
  } pulse_t;

  typedef struct packed {
    logic        we;
    logic [31:0] rdata;
    logic [31:0] acc;
    logic [31:0] lat;
  } resp_t;

  pulse_t pq[$];
  resp_t  rq[$];
  logic [15:0] sh [0:1][0:255];

  int n_cmp = 0;
  int n_fail = 0;
  int obs_addr[$];
  int resp_cyc_q[$];
  logic [31:0] last_rdata = '0;
  int last_lat = 0;
  int n_resp = 0;
  pulse_t cp_p;
  resp_t  cp_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the expected pulse/response queues.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("rd_wr_exclusive", {31'd0, psram_read_en && psram_write_en}, 32'd0);
      if (rq.size() != 0) chk("ready_low_while_busy_word", {31'd0, req_ready}, 32'd0);
      if (psram_read_en || psram_write_en) begin
        obs_addr.push_back(int'(psram_addr));
        chk("enable_while_ctrl_busy", {31'd0, psram_busy}, 32'd0);
        if (pq.size() == 0) begin
          chk("unexpected_pulse", {31'd0, psram_read_en | psram_write_en}, 32'd0);
        end else begin
          cp_p = pq.pop_front();
          chk("pulse_is_write", {31'd0, psram_write_en}, {31'd0, cp_p.we});
          chk("pulse_bank", {31'd0, psram_bank_sel}, {31'd0, cp_p.bank});
          chk("pulse_addr", {10'd0, psram_addr}, {10'd0, cp_p.addr});
          chk("pulse_high_byte", {31'd0, psram_write_high_byte}, {31'd0, cp_p.hb});
          chk("pulse_low_byte", {31'd0, psram_write_low_byte}, {31'd0, cp_p.lb});
          if (cp_p.we) chk("pulse_wdata", {16'd0, psram_data_in}, {16'd0, cp_p.data});
        end
      end
      if (resp_valid) begin
        if (rq.size() == 0) begin
          chk("unexpected_resp", {31'd0, resp_valid}, 32'd0);
        end else begin
          cp_r = rq.pop_front();
          chk("resp_latency", cyc - cp_r.acc, cp_r.lat);
          if (!cp_r.we) chk("resp_rdata", resp_rdata, cp_r.rdata);
          last_rdata = resp_rdata;
          last_lat   = cyc - int'(cp_r.acc);
          resp_cyc_q.push_back(cyc);
          n_resp++;
        end
      end
    end
  end

  // Drive one request, then queue the pulses and response the word implies.
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input bit exp_resp, output int acc);
    int k;
    int n;
    pulse_t pp;
    resp_t rr;
    logic [21:0] lo_a;
    logic [7:0] lo_i;
    logic bk;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      chk("accept_timeout", {31'd0, req_ready}, 32'd1);
      acc = -1;
      return;
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    acc = cyc;
    @(posedge clk);
    bk   = addr[23];
    lo_a = 22'((addr & 32'h007F_FFFC) >> 1);
    lo_i = lo_a[7:0];
    n = 0;
    rr.rdata = '0;
    if (!we) begin
      pp = '{we:1'b0, bank:bk, addr:lo_a, data:16'h0, hb:1'b1, lb:1'b1};
      pq.push_back(pp);
      pp.addr = lo_a + 22'd1;
      pq.push_back(pp);
      rr.rdata = {sh[bk][lo_i + 8'd1], sh[bk][lo_i]};
      n = 2;
    end else begin
      if (strb[1:0] != 2'b00) begin
        pp = '{we:1'b1, bank:bk, addr:lo_a, data:wdata[15:0], hb:strb[1], lb:strb[0]};
        pq.push_back(pp);
        if (strb[1]) sh[bk][lo_i][15:8] = wdata[15:8];
        if (strb[0]) sh[bk][lo_i][7:0]  = wdata[7:0];
        n++;
      end
      if (strb[3:2] != 2'b00) begin
        pp = '{we:1'b1, bank:bk, addr:lo_a + 22'd1, data:wdata[31:16], hb:strb[3], lb:strb[2]};
        pq.push_back(pp);
        if (strb[3]) sh[bk][lo_i + 8'd1][15:8] = wdata[31:24];
        if (strb[2]) sh[bk][lo_i + 8'd1][7:0]  = wdata[23:16];
        n++;
      end
    end
    rr.we  = we;
    rr.acc = acc;
    rr.lat = (n == 0) ? 32'd1 : 32'(n * (2 + b_cfg) + 1);
    if (exp_resp) rq.push_back(rr);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    @(negedge clk);
    while ((rq.size() != 0 || pq.size() != 0 || !req_ready) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("drain_resp_queue", rq.size(), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc1, acc2, k, resp_before;
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 256; a++) sh[b][a] = 16'h0000;
    sh[0][8] = 16'hBEEF;
    sh[0][9] = 16'hDEAD;
    b_cfg = 3;

    repeat (3) @(negedge clk);
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_read_en", {31'd0, psram_read_en}, 32'd0);
    chk("reset_write_en", {31'd0, psram_write_en}, 32'd0);
    chk("reset_addr", {10'd0, psram_addr}, 32'd0);
    chk("reset_rdata", resp_rdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // Word read, B=3
    obs_addr.delete();
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b1, acc);
    wait_done();
    chk("read_pulse_count", obs_addr.size(), 32'd2);
    if (obs_addr.size() == 2) begin
      chk("read_lo_addr", obs_addr[0], 32'd8);
      chk("read_hi_addr", obs_addr[1], 32'd9);
    end
    chk("read_word_literal", last_rdata, 32'hDEADBEEF);
    chk("read_latency_literal", last_lat, 32'd11);

    // Full write into bank 1
    obs_addr.delete();
    do_req(1'b1, 32'h0080_0004, 32'h1234_5678, 4'b1111, 1'b1, acc);
    wait_done();
    chk("full_write_pulses", obs_addr.size(), 32'd2);
    chk("full_write_lo_mem", {16'd0, mem[1][2]}, 32'h5678);
    chk("full_write_hi_mem", {16'd0, mem[1][3]}, 32'h1234);
    chk("rdata_holds_after_write", resp_rdata, 32'hDEADBEEF);
    chk("resp_count_after_write", n_resp, 32'd2);

    // Partial write: only byte 2
    obs_addr.delete();
    do_req(1'b1, 32'h0000_0010, 32'h00AB_0000, 4'b0100, 1'b1, acc);
    wait_done();
    chk("partial_pulse_count", obs_addr.size(), 32'd1);
    if (obs_addr.size() == 1) chk("partial_hi_addr", obs_addr[0], 32'd9);
    chk("partial_hi_mem", {16'd0, mem[0][9]}, 32'hDEAB);
    chk("partial_lo_untouched", {16'd0, mem[0][8]}, 32'hBEEF);
    chk("partial_latency_literal", last_lat, 32'd6);

    // Write with no strobes
    obs_addr.delete();
    do_req(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 1'b1, acc);
    wait_done();
    chk("nostrobe_pulse_count", obs_addr.size(), 32'd0);
    chk("nostrobe_latency_literal", last_lat, 32'd1);

    // Back-to-back write then read
    resp_cyc_q.delete();
    do_req(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'b1111, 1'b1, acc1);
    do_req(1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b1, acc2);
    wait_done();
    chk("b2b_resp_count", resp_cyc_q.size(), 32'd2);
    if (resp_cyc_q.size() >= 1) chk("b2b_accept_after_resp", acc2, resp_cyc_q[0] + 1);
    chk("b2b_read_literal", last_rdata, 32'hCAFEF00D);

    // Reset during WAIT of the LO half of a read
    b_cfg = 8;
    resp_before = n_resp;
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, acc);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    pq.delete();
    #1;
    chk("midreset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("midreset_enables", {30'd0, psram_read_en, psram_write_en}, 32'd0);
    chk("midreset_addr", {10'd0, psram_addr}, 32'd0);
    chk("midreset_data_in", {16'd0, psram_data_in}, 32'd0);
    chk("midreset_bank_bytes", {29'd0, psram_bank_sel, psram_write_high_byte, psram_write_low_byte}, 32'd0);
    chk("midreset_rdata", resp_rdata, 32'd0);
    chk("midreset_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    k = 0;
    while (psram_busy && k < 50) begin
      chk("ready_low_ctrl_busy", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      k++;
    end
    chk("ready_after_busy_falls", {31'd0, req_ready}, 32'd1);
    chk("no_resp_after_abort", n_resp, resp_before);

    // Slow controller, B=20, after the abort
    b_cfg = 20;
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b1, acc);
    wait_done();
    chk("slow_read_literal", last_rdata, 32'hDEABBEEF);
    chk("slow_latency_literal", last_lat, 32'd45);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
